// File: rtl/burst_write_master_pkg.sv
// Shared definitions for the bursting write master.
//   state_t    : FSM state encoding (ST_IDLE, ST_BURST)
//   burst_size : beats in the next burst, given the word offset inside a
//                MAXBURSTCOUNT-word line, the words still to write and the
//                line size. A burst never runs past the end of its line.
package burst_write_master_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic logic [31:0] burst_size(
        input logic [31:0] offset,
        input logic [31:0] words,
        input logic [31:0] max_burst
    );
        logic [31:0] room;
        room = (offset != 32'd0) ? (max_burst - offset) : max_burst;
        return (words < room) ? words : room;
    endfunction

endpackage

// File: rtl/burst_write_master_fifo.sv
// Show-ahead synchronous FIFO holding user write data for the write master.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   push        : write push_data; ignored while full
//   push_data   : data to store
//   pop         : drop the head word; ignored while empty
//   head_data   : current head word (valid whenever empty == 0)
//   usedw       : words held, DEPTH_LOG2+1 bits so a full FIFO is representable
//   full, empty : status flags
// USE_MEMORY = 1 keeps the storage free of reset so it can map to RAM;
// USE_MEMORY = 0 builds it from resettable flops.
module burst_write_fifo #(
    parameter int DATAWIDTH  = 32,
    parameter int DEPTH      = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter int USE_MEMORY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATAWIDTH-1:0]  push_data,
    input  logic                  pop,
    output logic [DATAWIDTH-1:0]  head_data,
    output logic [DEPTH_LOG2:0]   usedw,
    output logic                  full,
    output logic                  empty
);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full  = (usedw == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (usedw == '0);

    // Full is evaluated before the pop, so a push into a full FIFO is dropped
    // even when a pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   usedw <= usedw + 1'b1;
                2'b01:   usedw <= usedw - 1'b1;
                default: usedw <= usedw;
            endcase
        end
    end

    generate
        if (USE_MEMORY != 0) begin : g_ram
            logic [DATAWIDTH-1:0] mem [DEPTH];
            always_ff @(posedge clk) begin
                if (push_ok) mem[wr_ptr] <= push_data;
            end
            assign head_data = mem[rd_ptr];
        end else begin : g_regs
            logic [DATAWIDTH-1:0] regs [DEPTH];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
                end else if (push_ok) begin
                    regs[wr_ptr] <= push_data;
                end
            end
            assign head_data = regs[rd_ptr];
        end
    endgenerate

endmodule

// File: rtl/burst_write_master.sv
// Avalon-MM bursting write master. User logic fills an internal FIFO; after
// control_go the block writes control_write_length bytes starting at
// control_write_base, in bursts that never cross a MAXBURSTCOUNT-word line,
// and raises control_done when finished.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   control_fixed_location   : keep the same address for every burst
//   control_write_base/length: byte start address / byte count
//   control_go               : one-cycle start pulse (ignored mid-burst)
//   control_done             : nothing left to write and idle
//   user_write_buffer/data   : FIFO push port; user_buffer_full = FIFO full
//   master_*                 : Avalon-MM bursting write interface
//
// state    | meaning
// ST_IDLE  | waiting for go, or for the FIFO to hold the whole next burst
// ST_BURST | master_write high; beats go out as waitrequest allows
module burst_write_master
    import burst_write_master_pkg::*;
#(
    parameter int DATAWIDTH       = 32,
    parameter int MAXBURSTCOUNT   = 4,
    parameter int BURSTCOUNTWIDTH = 3,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int ADDRESSWIDTH    = 32,
    parameter int FIFODEPTH       = 32,
    parameter int FIFODEPTH_LOG2  = 5,
    parameter int FIFOUSEMEMORY   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    control_write_base,
    input  logic [ADDRESSWIDTH-1:0]    control_write_length,
    input  logic                       control_go,
    output logic                       control_done,
    input  logic                       user_write_buffer,
    input  logic [DATAWIDTH-1:0]       user_buffer_data,
    output logic                       user_buffer_full,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_write,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    output logic [DATAWIDTH-1:0]       master_writedata,
    output logic [BURSTCOUNTWIDTH-1:0] master_burstcount,
    input  logic                       master_waitrequest
);

    localparam int BE_LOG2 = $clog2(BYTEENABLEWIDTH);
    localparam int MB_LOG2 = $clog2(MAXBURSTCOUNT);

    state_t                     state;
    state_t                     state_next;
    logic [ADDRESSWIDTH-1:0]    length;
    logic [BURSTCOUNTWIDTH-1:0] beats_left;
    logic                       fixed_d1;

    logic [FIFODEPTH_LOG2:0]    fifo_used;
    logic                       fifo_empty;
    logic [MB_LOG2-1:0]         offset;
    logic [ADDRESSWIDTH-1:0]    words;
    logic [31:0]                next_count_full;
    logic [BURSTCOUNTWIDTH-1:0] next_count;
    logic                       load_go;
    logic                       start_burst;
    logic                       accept;
    logic                       last_beat;

    // Word position inside the current MAXBURSTCOUNT-word line.
    assign offset          = master_address[BE_LOG2 +: MB_LOG2];
    assign words           = length >> BE_LOG2;
    assign next_count_full = burst_size(32'(offset), 32'(words), 32'(MAXBURSTCOUNT));
    assign next_count      = BURSTCOUNTWIDTH'(next_count_full);
    assign last_beat       = (beats_left == BURSTCOUNTWIDTH'(1));

    always_comb begin
        state_next   = state;
        master_write = 1'b0;
        load_go      = 1'b0;
        start_burst  = 1'b0;
        accept       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (control_go) begin
                    load_go = 1'b1;
                end else if ((length != '0) && (32'(fifo_used) >= next_count_full)) begin
                    start_burst = 1'b1;
                    state_next  = ST_BURST;
                end
            end
            ST_BURST: begin
                master_write = 1'b1;
                // A burst only starts once the FIFO holds all of it, so empty
                // never gates a beat in practice; it just keeps pops safe.
                accept = !master_waitrequest && !fifo_empty;
                if (accept && last_beat) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            master_address    <= '0;
            length            <= '0;
            fixed_d1          <= 1'b0;
            beats_left        <= '0;
            master_burstcount <= '0;
        end else begin
            state <= state_next;
            if (load_go) begin
                master_address <= control_write_base;
                length         <= control_write_length;
                fixed_d1       <= control_fixed_location;
            end
            if (start_burst) begin
                master_burstcount <= next_count;
                beats_left        <= next_count;
            end
            if (accept) begin
                beats_left <= beats_left - 1'b1;
                length     <= length - ADDRESSWIDTH'(BYTEENABLEWIDTH);
                // Address stays put for the whole burst and steps once at its end.
                if (last_beat && !fixed_d1) begin
                    master_address <= master_address +
                                      (ADDRESSWIDTH'(master_burstcount) << BE_LOG2);
                end
            end
        end
    end

    assign control_done      = (length == '0) && (state == ST_IDLE);
    assign master_byteenable = '1;

    burst_write_fifo #(
        .DATAWIDTH  (DATAWIDTH),
        .DEPTH      (FIFODEPTH),
        .DEPTH_LOG2 (FIFODEPTH_LOG2),
        .USE_MEMORY (FIFOUSEMEMORY)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (user_write_buffer),
        .push_data (user_buffer_data),
        .pop       (accept),
        .head_data (master_writedata),
        .usedw     (fifo_used),
        .full      (user_buffer_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_burst_write_master.sv
module tb_burst_write_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        control_fixed_location = 1'b0;
    logic [31:0] control_write_base = '0;
    logic [31:0] control_write_length = '0;
    logic        control_go = 1'b0;
    logic        control_done;
    logic        user_write_buffer = 1'b0;
    logic [31:0] user_buffer_data = '0;
    logic        user_buffer_full;
    logic [31:0] master_address;
    logic        master_write;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata;
    logic [2:0]  master_burstcount;
    logic        master_waitrequest = 1'b0;

    int total = 0;
    int bad   = 0;
    int write_cycles = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] q_bc[$];

    always #5 clk = ~clk;

    burst_write_master u_dut (
        .clk                    (clk),
        .reset                  (reset),
        .control_fixed_location (control_fixed_location),
        .control_write_base     (control_write_base),
        .control_write_length   (control_write_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .user_write_buffer      (user_write_buffer),
        .user_buffer_data       (user_buffer_data),
        .user_buffer_full       (user_buffer_full),
        .master_address         (master_address),
        .master_write           (master_write),
        .master_byteenable      (master_byteenable),
        .master_writedata       (master_writedata),
        .master_burstcount      (master_burstcount),
        .master_waitrequest     (master_waitrequest)
    );

    // Record every beat the slave accepts.
    always @(posedge clk) begin
        if (master_write) begin
            write_cycles++;
            if (!master_waitrequest) begin
                q_addr.push_back(master_address);
                q_data.push_back(master_writedata);
                q_bc.push_back(32'(master_burstcount));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_bc.delete();
        write_cycles = 0;
    endtask

    task automatic push_words(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            user_write_buffer = 1'b1;
            user_buffer_data  = first + 32'(i);
            step();
        end
        user_write_buffer = 1'b0;
    endtask

    task automatic go(input logic [31:0] base, input logic [31:0] len, input logic fixed);
        control_write_base     = base;
        control_write_length   = len;
        control_fixed_location = fixed;
        control_go             = 1'b1;
        step();
        control_go = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        while (!control_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(control_done), 32'd1);
        step();
    endtask

    task automatic wait_write(input string tag);
        int n = 0;
        @(negedge clk);
        while (!master_write && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(master_write), 32'd1);
    endtask

    task automatic check_beats(input string tag, input int n, input logic [31:0] a0,
                               input logic [31:0] a1, input int split,
                               input logic [31:0] d0, input logic [31:0] bc0,
                               input logic [31:0] bc1);
        chk({tag, "_count"}, 32'(q_addr.size()), 32'(n));
        for (int i = 0; i < n && i < q_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), q_addr[i], (i < split) ? a0 : a1);
            chk($sformatf("%s_data%0d", tag, i), q_data[i], d0 + 32'(i));
            chk($sformatf("%s_bc%0d", tag, i), q_bc[i], (i < split) ? bc0 : bc1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        step();
        step();
        chk("rst_write", 32'(master_write), 32'd0);
        chk("rst_done", 32'(control_done), 32'd1);
        chk("rst_full", 32'(user_buffer_full), 32'd0);
        chk("rst_bc", 32'(master_burstcount), 32'd0);
        chk("rst_addr", master_address, 32'd0);
        reset = 1'b0;
        step();
        chk("byteenable", 32'(master_byteenable), 32'hF);

        // Aligned: two bursts of 4.
        push_words(32'hA0, 8);
        clear_log();
        go(32'h100, 32'd32, 1'b0);
        chk("t1_busy", 32'(control_done), 32'd0);
        n = 0;
        while (q_addr.size() < 8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t1_done_after_last", 32'(control_done), 32'd1);
        chk("t1_write_cycles", 32'(write_cycles), 32'd8);
        check_beats("t1", 8, 32'h100, 32'h110, 4, 32'hA0, 32'd4, 32'd4);
        step();

        // Unaligned start: 3 beats up to the line end, then 3 more.
        clear_log();
        push_words(32'hB0, 6);
        go(32'h104, 32'd24, 1'b0);
        wait_done("t2_done");
        check_beats("t2", 6, 32'h104, 32'h110, 3, 32'hB0, 32'd3, 32'd3);

        // No burst until the FIFO holds all 4 words.
        clear_log();
        go(32'h200, 32'd16, 1'b0);
        push_words(32'hC0, 3);
        repeat (5) step();
        chk("t3_no_write", 32'(write_cycles), 32'd0);
        push_words(32'hC3, 1);
        wait_done("t3_done");
        check_beats("t3", 4, 32'h200, 32'h200, 4, 32'hC0, 32'd4, 32'd4);

        // Stall for 5 cycles after the first beat.
        clear_log();
        push_words(32'hD0, 4);
        go(32'h300, 32'd16, 1'b0);
        wait_write("t4_write");
        @(posedge clk);
        #1;
        master_waitrequest = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t4_addr_hold", master_address, 32'h300);
            chk("t4_bc_hold", 32'(master_burstcount), 32'd4);
            chk("t4_data_hold", master_writedata, 32'hD1);
            chk("t4_beats_hold", 32'(q_addr.size()), 32'd1);
            chk("t4_len_hold", u_dut.length, 32'd12);
        end
        @(posedge clk);
        #1;
        master_waitrequest = 1'b0;
        wait_done("t4_done");
        check_beats("t4", 4, 32'h300, 32'h300, 4, 32'hD0, 32'd4, 32'd4);

        // Fixed location: both bursts at 0x40.
        clear_log();
        push_words(32'hE0, 8);
        go(32'h40, 32'd32, 1'b1);
        wait_done("t5_done");
        check_beats("t5", 8, 32'h40, 32'h40, 4, 32'hE0, 32'd4, 32'd4);

        // Fill the FIFO; the 33rd push is dropped.
        push_words(32'h100, 31);
        chk("t5_not_full31", 32'(user_buffer_full), 32'd0);
        push_words(32'h11F, 1);
        chk("t5_full32", 32'(user_buffer_full), 32'd1);
        push_words(32'hDEAD, 1);
        chk("t5_full33", 32'(user_buffer_full), 32'd1);
        clear_log();
        go(32'h1000, 32'd128, 1'b0);
        wait_done("t5_drain_done");
        chk("t5_drain_count", 32'(q_data.size()), 32'd32);
        if (q_data.size() == 32) begin
            chk("t5_first", q_data[0], 32'h100);
            chk("t5_last", q_data[31], 32'h11F);
            chk("t5_last_addr", q_addr[31], 32'h1070);
        end
        chk("t5_full_after", 32'(user_buffer_full), 32'd0);

        // Reset during beat 2 of 4.
        clear_log();
        push_words(32'hF0, 4);
        go(32'h500, 32'd16, 1'b0);
        wait_write("t6_write");
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_write_low", 32'(master_write), 32'd0);
        chk("t6_done", 32'(control_done), 32'd1);
        chk("t6_full", 32'(user_buffer_full), 32'd0);
        chk("t6_empty", 32'(u_dut.u_fifo.empty), 32'd1);
        chk("t6_bc", 32'(master_burstcount), 32'd0);
        step();
        reset = 1'b0;
        step();
        clear_log();
        push_words(32'h70, 4);
        go(32'h600, 32'd16, 1'b0);
        wait_done("t6_done2");
        check_beats("t6", 4, 32'h600, 32'h600, 4, 32'h70, 32'd4, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
